// File: rtl/pipelined_logic_unit.sv
// Two-stage pipelined bitwise logic unit with an accumulator operand.
// S1 captures the offered operation; S2 evaluates it against either x or
// the accumulator and registers the result with its zero/parity flags.
// The accumulator tracks the most recent valid result, so chained
// use_acc operations see the immediately preceding result.
//
// Handshake: an operation transfers on a rising edge when in_valid and
// in_ready are both 1; a result transfers when out_valid and out_ready are
// both 1. The whole pipe advances together (adv = !out_valid | out_ready),
// in_ready equals adv, and while a result is stalled every stage holds.
module pipelined_logic_unit #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [2:0]   op,
    input  logic         use_acc,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] f,
    output logic         zero,
    output logic         parity,
    output logic [W-1:0] acc_o
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOTA = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    // S1 registers
    logic [W-1:0] s1_x_q;
    logic [W-1:0] s1_y_q;
    logic [2:0]   s1_op_q;
    logic         s1_use_acc_q;
    logic         s1_valid_q;

    // S2 registers and accumulator
    logic [W-1:0] f_q;
    logic         zero_q;
    logic         parity_q;
    logic         out_valid_q;
    logic [W-1:0] acc_q;

    // Next-state values
    logic         adv;
    logic [W-1:0] a_d;
    logic [W-1:0] res_d;
    logic [W-1:0] acc_d;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign acc_o     = acc_q;

    // S2 evaluation: pick the first operand and decode the opcode.
    always_comb begin
        a_d   = s1_use_acc_q ? acc_q : s1_x_q;
        res_d = '0;
        unique case (s1_op_q)
            OP_AND:  res_d = a_d & s1_y_q;
            OP_OR:   res_d = a_d | s1_y_q;
            OP_XOR:  res_d = a_d ^ s1_y_q;
            OP_NOTA: res_d = ~a_d;
            OP_NAND: res_d = ~(a_d & s1_y_q);
            OP_NOR:  res_d = ~(a_d | s1_y_q);
            OP_XNOR: res_d = ~(a_d ^ s1_y_q);
            OP_PASS: res_d = s1_y_q;
            default: res_d = '0;
        endcase
    end

    // Accumulator next value: clear wins over a load; bubbles never load.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (adv && s1_valid_q) begin
            acc_d = res_d;
        end
    end

    // S1 capture of the offered operation; an empty slot becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_op_q      <= '0;
            s1_use_acc_q <= 1'b0;
            s1_valid_q   <= 1'b0;
        end else if (adv) begin
            s1_x_q       <= x;
            s1_y_q       <= y;
            s1_op_q      <= op;
            s1_use_acc_q <= use_acc;
            s1_valid_q   <= in_valid;
        end
    end

    // S2 result register with flags derived from the same value as f.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q         <= '0;
            zero_q      <= 1'b1;
            parity_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (adv) begin
            f_q         <= res_d;
            zero_q      <= (res_d == '0);
            parity_q    <= ^res_d;
            out_valid_q <= s1_valid_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Self-checking bench for pipelined_logic_unit (W = 8): directed table and
// sequences, then random traffic against a transaction-level model.
module tb_pipelined_logic_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   op;
    logic         use_acc;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         zero;
    logic         parity;
    logic [W-1:0] acc_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc_m;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] exp_f;
        logic         exp_zero;
        logic         exp_par;
    } vec_t;

    vec_t tbl[8];

    pipelined_logic_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .op        (op),
        .use_acc   (use_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .zero      (zero),
        .parity    (parity),
        .acc_o     (acc_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference operation straight from the opcode table
    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~a;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return b;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic v, input logic [W-1:0] xx, input logic [W-1:0] yy,
                        input logic [2:0] o, input logic ua, input logic clr, input logic rdy);
        in_valid  = v;
        x         = xx;
        y         = yy;
        op        = o;
        use_acc   = ua;
        acc_clr   = clr;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic         acc_v;
        logic         cons_v;
        logic         stall_v;
        logic [W-1:0] saved_f;
        logic [W-1:0] e;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [2:0]   rop;
        logic         rua;

        tbl[0] = '{3'd0, 8'h80, 1'b0, 1'b1};
        tbl[1] = '{3'd1, 8'hFF, 1'b0, 1'b0};
        tbl[2] = '{3'd2, 8'h7F, 1'b0, 1'b1};
        tbl[3] = '{3'd3, 8'h4C, 1'b0, 1'b1};
        tbl[4] = '{3'd4, 8'h7F, 1'b0, 1'b1};
        tbl[5] = '{3'd5, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{3'd6, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{3'd7, 8'hCC, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; op = '0; use_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_f", f, 8'h00);
        check("rst_zero", zero, 1'b1);
        check("rst_parity", parity, 1'b0);
        check("rst_acc", acc_o, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // streaming: one op per cycle, result two cycles after acceptance
        for (int i = 0; i < 10; i++) begin
            if (i < 8) step(1'b1, 8'hB3, 8'hCC, tbl[i].op, 1'b0, 1'b0, 1'b1);
            else       idle();
            if (i == 0) check("stream_empty_ov", out_valid, 1'b0);
            if (i >= 1 && i <= 8) begin
                check($sformatf("stream_f_op%0d", i - 1), f, tbl[i-1].exp_f);
                check($sformatf("stream_zero_op%0d", i - 1), zero, tbl[i-1].exp_zero);
                check($sformatf("stream_par_op%0d", i - 1), parity, tbl[i-1].exp_par);
                check($sformatf("stream_ov_op%0d", i - 1), out_valid, 1'b1);
            end
        end
        check("stream_acc", acc_o, 8'hCC);

        // accumulate chain
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        check("chain_clr_acc", acc_o, 8'h00);
        step(1'b1, 8'hAA, 8'h0F, 3'd1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 8'hFF, 3'd2, 1'b1, 1'b0, 1'b1);
        check("chain_f0", f, 8'h0F);
        step(1'b1, 8'hAA, 8'h3C, 3'd0, 1'b1, 1'b0, 1'b1);
        check("chain_f1", f, 8'hF0);
        idle();
        check("chain_f2", f, 8'h30);
        check("chain_acc", acc_o, 8'h30);

        // backpressure with two operations in flight
        step(1'b1, 8'h11, 8'h22, 3'd1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h0F, 8'hF0, 3'd2, 1'b0, 1'b0, 1'b1);
        check("bp_first_f", f, 8'h33);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h99, 8'h99, 3'd7, 1'b0, 1'b0, 1'b0);
            check($sformatf("bp_hold_f%0d", i), f, 8'h33);
            check($sformatf("bp_hold_ov%0d", i), out_valid, 1'b1);
            check($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
        end
        idle();
        check("bp_second_f", f, 8'hFF);
        check("bp_second_ov", out_valid, 1'b1);
        idle();
        check("bp_no_dup_ov", out_valid, 1'b0);

        // bubble between two valid ops; bubble fields would load 00 if it touched acc
        step(1'b1, 8'h00, 8'h5A, 3'd7, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'hFF, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
        check("bub_f0", f, 8'h5A);
        check("bub_ov0", out_valid, 1'b1);
        step(1'b1, 8'h00, 8'hFF, 3'd2, 1'b1, 1'b0, 1'b1);
        check("bub_ov1", out_valid, 1'b0);
        idle();
        check("bub_f2", f, 8'hA5);
        check("bub_ov2", out_valid, 1'b1);
        idle();
        check("bub_ov3", out_valid, 1'b0);

        // acc_clr colliding with a valid use_acc XOR
        step(1'b1, 8'h00, 8'h55, 3'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h00, 8'h0F, 3'd2, 1'b1, 1'b0, 1'b1);
        check("clr_acc_pre", acc_o, 8'h55);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        check("clr_f", f, 8'h5A);
        check("clr_acc_post", acc_o, 8'h00);

        // reset with S1 and S2 both full
        step(1'b1, 8'h00, 8'h11, 3'd7, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h00, 8'h22, 3'd7, 1'b0, 1'b0, 1'b1);
        check("mid_pre_ov", out_valid, 1'b1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ov", out_valid, 1'b0);
        check("mid_rst_acc", acc_o, 8'h00);
        check("mid_rst_f", f, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            check($sformatf("mid_post_ov%0d", i), out_valid, 1'b0);
        end
        step(1'b1, 8'h00, 8'h77, 3'd7, 1'b0, 1'b0, 1'b1);
        idle();
        check("mid_new_f", f, 8'h77);
        check("mid_new_ov", out_valid, 1'b1);
        idle();

        // random traffic against an in-order transaction model
        acc_m = 8'h77;
        for (int c = 0; c < 400; c++) begin
            rx  = W'($urandom);
            ry  = W'($urandom);
            rop = 3'($urandom_range(0, 7));
            rua = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 75);
            x = rx; y = ry; op = rop; use_acc = rua; acc_clr = 1'b0;
            #1;
            acc_v   = in_valid && in_ready;
            cons_v  = out_valid && out_ready;
            stall_v = out_valid && !out_ready;
            saved_f = f;
            if (cons_v) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_result", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_f", f, e);
                    check("rnd_zero", zero, (e == 8'h00));
                    check("rnd_parity", parity, ^e);
                end
            end
            if (acc_v) begin
                e = ref_op(rop, rua ? acc_m : rx, ry);
                acc_m = e;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (stall_v) begin
                check("rnd_stall_f", f, saved_f);
                check("rnd_stall_ov", out_valid, 1'b1);
            end
        end

        // drain with a bounded cycle budget
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b0; out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected_result", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("drain_f", f, e);
                end
            end
            @(posedge clk);
            #1;
        end
        check("drain_left", exp_q.size(), 0);
        check("rnd_acc", acc_o, acc_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
